codec_i2s_tx: RTL and testbench

//  Codec-side end of the sample stream. Issues the one-cycle new_sample_ready

---
 rtl/codec_i2s_tx.sv | 127 ++++++++++++
 tb/tb_codec_i2s_tx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/codec_i2s_tx.sv
// codec_i2s_tx: codec-side sample source / serializer.
//   Issues a one-cycle new_sample_ready pulse per audio frame, captures the
//   sample returned upstream at the last cycle of the frame, and shifts it out
//   MSB-first, left-justified, on both lrclk slots of the following frame.
// Ports:
//   clk               in   system clock, rising edge
//   reset             in   synchronous, active-high
//   sample_in         in   WIDTH-bit two's-complement sample
//   tx_enable         in   0 = mute (capture zeros)
//   new_sample_ready  out  one-cycle request pulse at frame start
//   bclk              out  serial bit clock
//   lrclk             out  0 = left slot, 1 = right slot
//   sdata             out  serial data, changes on bclk fall
module codec_i2s_tx #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned BCLK_HALF = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             tx_enable,
    output logic             new_sample_ready,
    output logic             bclk,
    output logic             lrclk,
    output logic             sdata
);

    localparam int unsigned SLOTS = 2 * WIDTH;
    localparam int unsigned PW    = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int unsigned SW    = $clog2(SLOTS);
    localparam int unsigned IW    = $clog2(WIDTH);

    // Frame position is held as (slot, bclk half, phase within half) rather
    // than a flat cycle count, so no dividers are needed to derive outputs.
    logic [PW-1:0]    ph_q, ph_d;
    logic             half_q, half_d;
    logic [SW-1:0]    slot_q, slot_d;
    // Cleared by reset; the first cycle after release shows position 0.
    logic             run_q, run_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;

    logic nsr_q, nsr_d;
    logic bclk_q, bclk_d;
    logic lrclk_q, lrclk_d;
    logic sdata_q, sdata_d;

    logic          half_end;
    logic          frame_end;
    logic [SW-1:0] slot_mod;
    logic [IW-1:0] bit_pos;

    always_comb begin
        ph_d      = ph_q;
        half_d    = half_q;
        slot_d    = slot_q;
        run_d     = run_q;
        hold_d    = hold_q;
        shreg_d   = shreg_q;
        half_end  = (ph_q == PW'(BCLK_HALF - 1));
        frame_end = half_end && half_q && (slot_q == SW'(SLOTS - 1));

        if (!run_q) begin
            run_d  = 1'b1;
            ph_d   = '0;
            half_d = 1'b0;
            slot_d = '0;
        end else begin
            if (half_end) begin
                ph_d   = '0;
                half_d = ~half_q;
                if (half_q) begin
                    slot_d = frame_end ? '0 : slot_q + SW'(1);
                end
            end else begin
                ph_d = ph_q + PW'(1);
            end
            // Capture and load share the wrap edge, so the sample captured at
            // the end of frame N is serialized throughout frame N+1.
            if (frame_end) begin
                hold_d  = tx_enable ? sample_in : '0;
                shreg_d = hold_d;
            end
        end

        // Outputs are registered from next-state so they line up with the
        // position they describe.
        nsr_d    = (ph_d == '0) && !half_d && (slot_d == '0);
        bclk_d   = half_d;
        lrclk_d  = (slot_d >= SW'(WIDTH));
        slot_mod = lrclk_d ? (slot_d - SW'(WIDTH)) : slot_d;
        bit_pos  = IW'(WIDTH - 1) - IW'(slot_mod);
        sdata_d  = shreg_d[bit_pos];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ph_q    <= '0;
            half_q  <= 1'b0;
            slot_q  <= '0;
            run_q   <= 1'b0;
            hold_q  <= '0;
            shreg_q <= '0;
            nsr_q   <= 1'b0;
            bclk_q  <= 1'b0;
            lrclk_q <= 1'b0;
            sdata_q <= 1'b0;
        end else begin
            ph_q    <= ph_d;
            half_q  <= half_d;
            slot_q  <= slot_d;
            run_q   <= run_d;
            hold_q  <= hold_d;
            shreg_q <= shreg_d;
            nsr_q   <= nsr_d;
            bclk_q  <= bclk_d;
            lrclk_q <= lrclk_d;
            sdata_q <= sdata_d;
        end
    end

    assign new_sample_ready = nsr_q;
    assign bclk             = bclk_q;
    assign lrclk            = lrclk_q;
    assign sdata            = sdata_q;

endmodule

// File: tb/tb_codec_i2s_tx.sv
// Bench for codec_i2s_tx at WIDTH=16, BCLK_HALF=2 (128-cycle frame).
module tb_codec_i2s_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sample_in;
    logic        tx_enable;
    logic        new_sample_ready;
    logic        bclk;
    logic        lrclk;
    logic        sdata;

    always #5 clk = ~clk;

    codec_i2s_tx #(
        .WIDTH     (16),
        .BCLK_HALF (2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .sample_in        (sample_in),
        .tx_enable        (tx_enable),
        .new_sample_ready (new_sample_ready),
        .bclk             (bclk),
        .lrclk            (lrclk),
        .sdata            (sdata)
    );

    typedef struct packed {
        logic nsr;
        logic bclk;
        logic lrclk;
        logic sdata;
    } out_t;

    typedef struct packed {
        logic [15:0] s_cap;
        logic [15:0] s_other;
        logic        en_cap;
        logic        en_other;
        logic [15:0] exp_word;
    } vec_t;

    out_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model of the frame position and the word on the wire.
    logic        m_run  = 1'b0;
    int          m_cyc  = 0;
    logic [15:0] m_word = '0;
    logic        prev_nsr = 1'b0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Drive one cycle, predict outputs, compare after the edge.
    task automatic tick(input logic r, input logic [15:0] s, input logic en);
        out_t e;
        out_t got;
        reset     = r;
        sample_in = s;
        tx_enable = en;
        if (r) begin
            m_run  = 1'b0;
            m_cyc  = 0;
            m_word = '0;
            e      = '0;
        end else begin
            if (!m_run) begin
                m_run = 1'b1;
                m_cyc = 0;
            end else if (m_cyc == 127) begin
                m_word = en ? s : 16'h0000;
                m_cyc  = 0;
            end else begin
                m_cyc++;
            end
            e.nsr   = (m_cyc == 0);
            e.bclk  = ((m_cyc / 2) % 2) == 1;
            e.lrclk = (m_cyc >= 64);
            e.sdata = m_word[15 - ((m_cyc / 4) % 16)];
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = {new_sample_ready, bclk, lrclk, sdata};
        check("cycle_out", int'(got), int'(exp_q.pop_front()));
        if (prev_nsr) check("nsr_not_double", int'(got.nsr), 0);
        prev_nsr = got.nsr;
        @(negedge clk);
    endtask

    // Runs one full frame starting at position 0, applying the given inputs at
    // the capture cycle and elsewhere, and collects what the frame carried.
    task automatic run_frame(input logic [15:0] s_cap, input logic [15:0] s_other,
                             input logic en_cap, input logic en_other,
                             output logic [15:0] left, output logic [15:0] right,
                             output int rises, output int unstable, output int pulses,
                             output int lr_rises);
        logic pb;
        logic ps;
        logic pl;
        left = '0; right = '0;
        rises = 0; unstable = 0; pulses = 0; lr_rises = 0;
        pb = 1'b0; ps = sdata; pl = lrclk;
        for (int c = 0; c < 128; c++) begin
            if (c % 4 == 2) begin
                if (c < 64) left[15 - c / 4] = sdata;
                else        right[15 - (c - 64) / 4] = sdata;
            end
            if (bclk && !pb) rises++;
            if (bclk && pb && (sdata != ps)) unstable++;
            if (lrclk && !pl) lr_rises++;
            if (new_sample_ready) pulses++;
            pb = bclk; ps = sdata; pl = lrclk;
            tick(1'b0, (c == 127) ? s_cap : s_other, (c == 127) ? en_cap : en_other);
        end
    endtask

    task automatic frame_checks(input logic [15:0] exp_word, input logic [15:0] left,
                                input logic [15:0] right, input int rises,
                                input int unstable, input int pulses, input int lr_rises);
        check("left_word", int'(left), int'(exp_word));
        check("right_word", int'(right), int'(exp_word));
        check("bclk_rises", rises, 32);
        check("sdata_stable_bclk_hi", unstable, 0);
        check("nsr_per_frame", pulses, 1);
        check("lrclk_rises", lr_rises, 1);
    endtask

    vec_t        vecs[6];
    logic [15:0] prev_exp;
    logic [15:0] l;
    logic [15:0] r;
    int          ri;
    int          un;
    int          pu;
    int          lr;

    initial begin
        vecs[0] = '{16'hA5C3, 16'hA5C3, 1'b1, 1'b1, 16'hA5C3};
        vecs[1] = '{16'h0001, 16'hFFFF, 1'b1, 1'b1, 16'h0001};
        vecs[2] = '{16'h7FFF, 16'h7FFF, 1'b0, 1'b1, 16'h0000};
        vecs[3] = '{16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 16'h7FFF};
        vecs[4] = '{16'h8000, 16'h1234, 1'b1, 1'b0, 16'h8000};
        vecs[5] = '{16'h0000, 16'hFFFF, 1'b1, 1'b1, 16'h0000};

        // Reset for three cycles: all outputs low.
        for (int i = 0; i < 3; i++) tick(1'b1, 16'hFFFF, 1'b1);
        // First cycle after release shows the request pulse.
        tick(1'b0, 16'hFFFF, 1'b1);
        check("first_pulse", int'(new_sample_ready), 1);

        // Frame 0 after reset carries zeros; each later frame carries the
        // previous frame's capture.
        prev_exp = 16'h0000;
        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].s_cap, vecs[i].s_other, vecs[i].en_cap, vecs[i].en_other,
                      l, r, ri, un, pu, lr);
            frame_checks(prev_exp, l, r, ri, un, pu, lr);
            prev_exp = vecs[i].exp_word;
        end
        run_frame(16'hBEEF, 16'h0000, 1'b1, 1'b1, l, r, ri, un, pu, lr);
        frame_checks(prev_exp, l, r, ri, un, pu, lr);

        // Mid-frame reset at position 70 while BEEF is on the wire.
        for (int c = 0; c < 70; c++) tick(1'b0, 16'h1111, 1'b1);
        check("pre_reset_pos", int'(lrclk), 1);
        tick(1'b1, 16'h1111, 1'b1);
        check("reset_outs", int'({new_sample_ready, bclk, lrclk, sdata}), 0);
        tick(1'b0, 16'h1111, 1'b1);
        check("pulse_after_reset", int'(new_sample_ready), 1);
        run_frame(16'h5A5A, 16'h0000, 1'b1, 1'b1, l, r, ri, un, pu, lr);
        frame_checks(16'h0000, l, r, ri, un, pu, lr);
        run_frame(16'h0000, 16'h0000, 1'b1, 1'b1, l, r, ri, un, pu, lr);
        frame_checks(16'h5A5A, l, r, ri, un, pu, lr);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
